calc1_port_sched: RTL and testbench

CALC1_PORT_SCHED -- requirements
Module: calc1_port_sched

---
 rtl/calc1_pkg.sv | 31 +++
 rtl/calc1_alu.sv | 108 ++++++++++
 rtl/calc1_port_sched.sv | 148 ++++++++++++++
 tb/tb_calc1_port_sched.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc1_pkg.sv
// Shared definitions for the four-port calculator: operand widths, command and
// response codes, and the per-port request state.
package calc1_pkg;

  localparam int DATA_W    = 32;
  localparam int SHAMT_W   = 5;
  localparam int NUM_PORTS = 4;
  localparam int PORT_W    = 2;

  typedef enum logic [3:0] {
    CMD_NONE = 4'd0,
    CMD_ADD  = 4'd1,
    CMD_SUB  = 4'd2,
    CMD_SHL  = 4'd5,
    CMD_SHR  = 4'd6
  } cmd_e;

  typedef enum logic [1:0] {
    RESP_NONE = 2'd0,
    RESP_OK   = 2'd1,
    RESP_ERR  = 2'd2
  } resp_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_D2,
    ST_PEND,
    ST_EXEC
  } port_state_e;

endpackage

// File: rtl/calc1_alu.sv
// Shared single-cycle ALU: operands register at the grant edge, the result with
// its response code and originating port registers one edge later.
module calc1_alu #(
  parameter int DATA_W  = calc1_pkg::DATA_W,
  parameter int SHAMT_W = calc1_pkg::SHAMT_W
) (
  input  logic              c_clk,
  input  logic              reset,
  input  logic              load,
  input  logic [0:3]        cmd,
  input  logic [0:DATA_W-1] data1,
  input  logic [0:DATA_W-1] data2,
  input  logic [1:0]        port_id,
  output logic [0:1]        res_resp,
  output logic [0:DATA_W-1] res_data,
  output logic [1:0]        res_port
);
  import calc1_pkg::*;

  logic              op_valid_reg;
  logic [0:3]        op_cmd_reg;
  logic [0:DATA_W-1] op_d1_reg;
  logic [0:DATA_W-1] op_d2_reg;
  logic [1:0]        op_port_reg;

  logic [0:1]        res_resp_reg;
  logic [0:DATA_W-1] res_data_reg;
  logic [1:0]        res_port_reg;

  logic [0:1]        resp_next;
  logic [0:DATA_W-1] data_next;
  logic [0:DATA_W]   sum_ext;
  logic [0:SHAMT_W-1] shamt;

  always_ff @(posedge c_clk or posedge reset) begin
    if (reset) begin
      op_valid_reg <= 1'b0;
      op_cmd_reg   <= '0;
      op_d1_reg    <= '0;
      op_d2_reg    <= '0;
      op_port_reg  <= '0;
    end else begin
      op_valid_reg <= load;
      if (load) begin
        op_cmd_reg  <= cmd;
        op_d1_reg   <= data1;
        op_d2_reg   <= data2;
        op_port_reg <= port_id;
      end
    end
  end

  // Shift amount comes from the least-significant end of data2.
  assign shamt = op_d2_reg[DATA_W-SHAMT_W:DATA_W-1];

  always_comb begin
    sum_ext   = '0;
    resp_next = RESP_NONE;
    data_next = '0;
    if (op_valid_reg) begin
      case (op_cmd_reg)
        CMD_ADD: begin
          sum_ext = {1'b0, op_d1_reg} + {1'b0, op_d2_reg};
          if (sum_ext[0]) begin
            resp_next = RESP_ERR;
          end else begin
            resp_next = RESP_OK;
            data_next = sum_ext[1:DATA_W];
          end
        end
        CMD_SUB: begin
          if (op_d2_reg > op_d1_reg) begin
            resp_next = RESP_ERR;
          end else begin
            resp_next = RESP_OK;
            data_next = op_d1_reg - op_d2_reg;
          end
        end
        CMD_SHL: begin
          resp_next = RESP_OK;
          data_next = op_d1_reg << shamt;
        end
        CMD_SHR: begin
          resp_next = RESP_OK;
          data_next = op_d1_reg >> shamt;
        end
        default: resp_next = RESP_ERR;
      endcase
    end
  end

  always_ff @(posedge c_clk or posedge reset) begin
    if (reset) begin
      res_resp_reg <= RESP_NONE;
      res_data_reg <= '0;
      res_port_reg <= '0;
    end else begin
      res_resp_reg <= resp_next;
      res_data_reg <= data_next;
      res_port_reg <= op_port_reg;
    end
  end

  assign res_resp = res_resp_reg;
  assign res_data = res_data_reg;
  assign res_port = res_port_reg;

endmodule

// File: rtl/calc1_port_sched.sv
// Four request ports sharing one ALU: each port collects a two-beat request,
// then waits for a round-robin grant; results return to the originating port.
module calc1_port_sched #(
  parameter int DATA_W  = calc1_pkg::DATA_W,
  parameter int SHAMT_W = calc1_pkg::SHAMT_W
) (
  input  logic              c_clk,
  input  logic              reset,
  input  logic [0:3]        req1_cmd_in,
  input  logic [0:3]        req2_cmd_in,
  input  logic [0:3]        req3_cmd_in,
  input  logic [0:3]        req4_cmd_in,
  input  logic [0:DATA_W-1] req1_data_in,
  input  logic [0:DATA_W-1] req2_data_in,
  input  logic [0:DATA_W-1] req3_data_in,
  input  logic [0:DATA_W-1] req4_data_in,
  output logic [0:1]        out_resp1,
  output logic [0:1]        out_resp2,
  output logic [0:1]        out_resp3,
  output logic [0:1]        out_resp4,
  output logic [0:DATA_W-1] out_data1,
  output logic [0:DATA_W-1] out_data2,
  output logic [0:DATA_W-1] out_data3,
  output logic [0:DATA_W-1] out_data4,
  output logic [0:3]        busy
);
  import calc1_pkg::*;

  localparam int NP = NUM_PORTS;

  logic [0:3]        cmd_in   [NP];
  logic [0:DATA_W-1] data_in  [NP];
  logic [0:3]        cmd_q    [NP];
  logic [0:DATA_W-1] d1_q     [NP];
  logic [0:DATA_W-1] d2_q     [NP];
  logic [0:1]        resp_out [NP];
  logic [0:DATA_W-1] data_out [NP];
  logic [NP-1:0]     pend;

  logic [1:0]        rr_ptr_reg;
  logic              grant_valid;
  logic [1:0]        grant_idx;

  logic [0:1]        res_resp;
  logic [0:DATA_W-1] res_data;
  logic [1:0]        res_port;

  assign cmd_in[0]  = req1_cmd_in;
  assign cmd_in[1]  = req2_cmd_in;
  assign cmd_in[2]  = req3_cmd_in;
  assign cmd_in[3]  = req4_cmd_in;
  assign data_in[0] = req1_data_in;
  assign data_in[1] = req2_data_in;
  assign data_in[2] = req3_data_in;
  assign data_in[3] = req4_data_in;

  // Search wraps naturally in two bits, starting just after the last grant.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = rr_ptr_reg;
    for (int i = 0; i < NP; i++) begin
      if (!grant_valid && pend[rr_ptr_reg + 2'(i)]) begin
        grant_valid = 1'b1;
        grant_idx   = rr_ptr_reg + 2'(i);
      end
    end
  end

  always_ff @(posedge c_clk or posedge reset) begin
    if (reset) begin
      rr_ptr_reg <= '0;
    end else if (grant_valid) begin
      rr_ptr_reg <= grant_idx + 2'd1;
    end
  end

  for (genvar gi = 0; gi < NP; gi++) begin : g_port
    port_state_e       state_reg;
    logic [0:3]        cmd_reg;
    logic [0:DATA_W-1] d1_reg;
    logic [0:DATA_W-1] d2_reg;

    // EXEC lasts exactly one edge because the ALU latency is fixed.
    always_ff @(posedge c_clk or posedge reset) begin
      if (reset) begin
        state_reg <= ST_IDLE;
        cmd_reg   <= '0;
        d1_reg    <= '0;
        d2_reg    <= '0;
      end else begin
        case (state_reg)
          ST_IDLE: begin
            if (cmd_in[gi] != CMD_NONE) begin
              cmd_reg   <= cmd_in[gi];
              d1_reg    <= data_in[gi];
              state_reg <= ST_D2;
            end
          end
          ST_D2: begin
            d2_reg    <= data_in[gi];
            state_reg <= ST_PEND;
          end
          ST_PEND: begin
            if (grant_valid && grant_idx == 2'(gi)) begin
              state_reg <= ST_EXEC;
            end
          end
          ST_EXEC: state_reg <= ST_IDLE;
          default: state_reg <= ST_IDLE;
        endcase
      end
    end

    assign pend[gi]     = (state_reg == ST_PEND);
    assign busy[gi]     = (state_reg != ST_IDLE);
    assign cmd_q[gi]    = cmd_reg;
    assign d1_q[gi]     = d1_reg;
    assign d2_q[gi]     = d2_reg;
    assign resp_out[gi] = (res_port == 2'(gi)) ? res_resp : RESP_NONE;
    assign data_out[gi] = (res_port == 2'(gi)) ? res_data : '0;
  end

  calc1_alu #(
    .DATA_W  (DATA_W),
    .SHAMT_W (SHAMT_W)
  ) u_alu (
    .c_clk    (c_clk),
    .reset    (reset),
    .load     (grant_valid),
    .cmd      (cmd_q[grant_idx]),
    .data1    (d1_q[grant_idx]),
    .data2    (d2_q[grant_idx]),
    .port_id  (grant_idx),
    .res_resp (res_resp),
    .res_data (res_data),
    .res_port (res_port)
  );

  assign out_resp1 = resp_out[0];
  assign out_resp2 = resp_out[1];
  assign out_resp3 = resp_out[2];
  assign out_resp4 = resp_out[3];
  assign out_data1 = data_out[0];
  assign out_data2 = data_out[1];
  assign out_data3 = data_out[2];
  assign out_data4 = data_out[3];

endmodule

// File: tb/tb_calc1_port_sched.sv
// Scoreboard bench for calc1_port_sched: each scenario queues the responses it
// expects (port, resp, data, edge) and a negedge monitor matches DUT output.
module tb_calc1_port_sched;

  localparam int DW = 32;

  logic          c_clk = 1'b0;
  logic          reset;
  logic [0:3]    cmd_drv  [4];
  logic [0:DW-1] data_drv [4];
  logic [0:1]    out_resp [4];
  logic [0:DW-1] out_data [4];
  logic [0:3]    busy;

  int checks   = 0;
  int errors   = 0;
  int edge_cnt = 0;
  bit mon_en   = 1'b0;

  logic [0:3]    op_cmd [4];
  logic [0:DW-1] op_d1  [4];
  logic [0:DW-1] op_d2  [4];

  typedef struct {
    int            port;
    logic [0:1]    resp;
    logic [0:DW-1] data;
    int            at_edge;
  } exp_t;
  exp_t sb[$];

  calc1_port_sched dut (
    .c_clk        (c_clk),
    .reset        (reset),
    .req1_cmd_in  (cmd_drv[0]),
    .req2_cmd_in  (cmd_drv[1]),
    .req3_cmd_in  (cmd_drv[2]),
    .req4_cmd_in  (cmd_drv[3]),
    .req1_data_in (data_drv[0]),
    .req2_data_in (data_drv[1]),
    .req3_data_in (data_drv[2]),
    .req4_data_in (data_drv[3]),
    .out_resp1    (out_resp[0]),
    .out_resp2    (out_resp[1]),
    .out_resp3    (out_resp[2]),
    .out_resp4    (out_resp[3]),
    .out_data1    (out_data[0]),
    .out_data2    (out_data[1]),
    .out_data3    (out_data[2]),
    .out_data4    (out_data[3]),
    .busy         (busy)
  );

  always #5 c_clk = ~c_clk;
  always @(posedge c_clk) edge_cnt <= edge_cnt + 1;

  always @(negedge c_clk) begin
    int hit;
    if (mon_en) begin
      for (int p = 0; p < 4; p++) begin
        hit = -1;
        foreach (sb[i]) if (sb[i].port == p && sb[i].at_edge == edge_cnt) hit = i;
        if (hit >= 0) begin
          checks++;
          if (out_resp[p] !== sb[hit].resp || out_data[p] !== sb[hit].data) begin
            errors++;
            $display("FAIL resp_port%0d edge %0d: got resp %0d data %h, want resp %0d data %h",
                     p + 1, edge_cnt, out_resp[p], out_data[p], sb[hit].resp, sb[hit].data);
          end else begin
            $display("resp port%0d edge %0d resp %0d data %h", p + 1, edge_cnt, out_resp[p], out_data[p]);
          end
          sb.delete(hit);
        end else if (out_resp[p] !== 2'd0 || out_data[p] !== '0) begin
          checks++;
          errors++;
          $display("FAIL idle_port%0d edge %0d: got resp %0d data %h, want resp 0 data 0",
                   p + 1, edge_cnt, out_resp[p], out_data[p]);
        end
      end
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].at_edge < edge_cnt) begin
          checks++;
          errors++;
          $display("FAIL missed_resp port%0d due edge %0d: got nothing, want resp %0d data %h",
                   sb[i].port + 1, sb[i].at_edge, sb[i].resp, sb[i].data);
          sb.delete(i);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge c_clk);
    #1;
  endtask

  task automatic expect_resp(input int p, input logic [0:1] r, input logic [0:DW-1] d, input int at);
    exp_t e;
    e.port = p; e.resp = r; e.data = d; e.at_edge = at;
    sb.push_back(e);
  endtask

  // Drives data1 with the command at E0 and data2 at E1 for every port with a
  // queued op; returns #1 after E1.
  task automatic start_ops(output int e0);
    e0 = edge_cnt + 1;
    for (int p = 0; p < 4; p++) begin
      cmd_drv[p]  = op_cmd[p];
      data_drv[p] = op_d1[p];
    end
    tick(1);
    for (int p = 0; p < 4; p++) begin
      cmd_drv[p]  = '0;
      data_drv[p] = op_d2[p];
    end
    tick(1);
    for (int p = 0; p < 4; p++) begin
      data_drv[p] = '0;
      op_cmd[p]   = '0;
    end
  endtask

  function automatic void model(input logic [0:3] c, input logic [0:DW-1] a, input logic [0:DW-1] b,
                                output logic [0:1] r, output logic [0:DW-1] d);
    longint unsigned s;
    int sh;
    sh = int'(b % 32);
    r = 2'd2;
    d = '0;
    case (c)
      4'd1: begin
        s = a;
        s = s + b;
        if (s <= 64'hFFFF_FFFF) begin r = 2'd1; d = s[31:0]; end
      end
      4'd2: if (a >= b) begin r = 2'd1; d = a - b; end
      4'd5: begin r = 2'd1; d = a << sh; end
      4'd6: begin r = 2'd1; d = a >> sh; end
      default: ;
    endcase
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    for (int p = 0; p < 4; p++) begin
      cmd_drv[p] = '0; data_drv[p] = '0; op_cmd[p] = '0; op_d1[p] = '0; op_d2[p] = '0;
    end
    tick(3);
    checks++;
    if (busy !== 4'b0000) begin
      errors++; $display("FAIL reset_busy: got %b, want 0000", busy);
    end
    for (int p = 0; p < 4; p++) begin
      checks++;
      if (out_resp[p] !== 2'd0 || out_data[p] !== '0) begin
        errors++;
        $display("FAIL reset_out_port%0d: got resp %0d data %h, want 0/0", p + 1, out_resp[p], out_data[p]);
      end
    end
    reset = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic test_add_basic();
    int e0;
    op_cmd[0] = 4'd1; op_d1[0] = 32'h1; op_d2[0] = 32'h1FFF_FFFF;
    start_ops(e0);
    expect_resp(0, 2'd1, 32'h2000_0000, e0 + 3);
    tick(5);
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL add_basic_drain: got %0d left, want 0", sb.size()); end
  endtask

  task automatic test_errors();
    int e0;
    op_cmd[1] = 4'd1; op_d1[1] = 32'hFFFF_FFFF; op_d2[1] = 32'h1;
    op_cmd[2] = 4'd2; op_d1[2] = 32'h1;         op_d2[2] = 32'hF;
    start_ops(e0);
    expect_resp(1, 2'd2, 32'h0, e0 + 3);
    expect_resp(2, 2'd2, 32'h0, e0 + 4);
    tick(6);
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL errors_drain: got %0d left, want 0", sb.size()); end
  endtask

  task automatic test_all_ports();
    int e0;
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    for (int p = 0; p < 4; p++) begin
      op_cmd[p] = 4'd1; op_d1[p] = 32'h1; op_d2[p] = DW'(p + 1);
    end
    start_ops(e0);
    for (int p = 0; p < 4; p++) expect_resp(p, 2'd1, DW'(p + 2), e0 + 3 + p);
    checks++;
    if (busy !== 4'b1111) begin errors++; $display("FAIL all_busy_e1: got %b, want 1111", busy); end
    tick(2);
    checks++;
    if (busy !== 4'b0111) begin errors++; $display("FAIL all_busy_e3: got %b, want 0111", busy); end
    tick(1);
    checks++;
    if (busy !== 4'b0011) begin errors++; $display("FAIL all_busy_e4: got %b, want 0011", busy); end
    tick(2);
    checks++;
    if (busy !== 4'b0000) begin errors++; $display("FAIL all_busy_e6: got %b, want 0000", busy); end
    tick(2);
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL all_drain: got %0d left, want 0", sb.size()); end
  endtask

  task automatic test_round_robin();
    int e0;
    op_cmd[1] = 4'd1; op_d1[1] = 32'd2; op_d2[1] = 32'd2;
    start_ops(e0);
    expect_resp(1, 2'd1, 32'd4, e0 + 3);
    tick(3);
    // Last grant was port 2, so port 3 must win over port 1.
    op_cmd[0] = 4'd1; op_d1[0] = 32'd3; op_d2[0] = 32'd3;
    op_cmd[2] = 4'd2; op_d1[2] = 32'd9; op_d2[2] = 32'd4;
    start_ops(e0);
    expect_resp(2, 2'd1, 32'd5, e0 + 3);
    expect_resp(0, 2'd1, 32'd6, e0 + 4);
    tick(5);
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL rr_drain: got %0d left, want 0", sb.size()); end
  endtask

  task automatic test_pipeline();
    int e0;
    e0 = edge_cnt + 1;
    cmd_drv[0] = 4'd1; data_drv[0] = 32'd10;
    tick(1);
    cmd_drv[0] = '0; data_drv[0] = 32'd20;
    cmd_drv[1] = 4'd2; data_drv[1] = 32'd100;
    tick(1);
    data_drv[0] = '0; cmd_drv[1] = '0; data_drv[1] = 32'd30;
    tick(1);
    data_drv[1] = '0;
    expect_resp(0, 2'd1, 32'd30, e0 + 3);
    expect_resp(1, 2'd1, 32'd70, e0 + 4);
    tick(1);
    checks++;
    if (busy !== 4'b0100) begin errors++; $display("FAIL pipe_busy_e3: got %b, want 0100", busy); end
    tick(4);
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL pipe_drain: got %0d left, want 0", sb.size()); end
  endtask

  task automatic test_invalid_shift();
    int e0;
    logic [0:3]    cmds [4];
    logic [0:DW-1] d1s  [4];
    logic [0:DW-1] d2s  [4];
    logic [0:1]    rs   [4];
    logic [0:DW-1] ds   [4];
    cmds = '{4'd3, 4'd4, 4'd5, 4'd6};
    d1s  = '{32'd7, 32'd7, 32'h1, 32'h8000_0000};
    d2s  = '{32'd8, 32'd8, 32'd31, 32'd31};
    rs   = '{2'd2, 2'd2, 2'd1, 2'd1};
    ds   = '{32'h0, 32'h0, 32'h8000_0000, 32'h1};
    for (int k = 0; k < 4; k++) begin
      op_cmd[3] = cmds[k]; op_d1[3] = d1s[k]; op_d2[3] = d2s[k];
      start_ops(e0);
      expect_resp(3, rs[k], ds[k], e0 + 3);
      tick(2);
    end
    tick(3);
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL inv_shift_drain: got %0d left, want 0", sb.size()); end
  endtask

  task automatic test_back_to_back();
    int e0;
    logic [0:3]    pick [6];
    logic [0:1]    r;
    logic [0:DW-1] d;
    pick = '{4'd1, 4'd2, 4'd5, 4'd6, 4'd7, 4'd15};
    for (int k = 0; k < 10; k++) begin
      op_cmd[0] = pick[$urandom_range(0, 5)];
      op_d1[0]  = $urandom;
      op_d2[0]  = (k % 3 == 0) ? DW'($urandom_range(0, 255)) : $urandom;
      model(op_cmd[0], op_d1[0], op_d2[0], r, d);
      start_ops(e0);
      expect_resp(0, r, d, e0 + 3);
      tick(2);
    end
    tick(3);
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL b2b_drain: got %0d left, want 0", sb.size()); end
  endtask

  task automatic test_ignore_pend();
    int e0;
    e0 = edge_cnt + 1;
    cmd_drv[0] = 4'd1; data_drv[0] = 32'd5;
    tick(1);
    data_drv[0] = 32'd6;
    tick(1);
    data_drv[0] = 32'd99;
    tick(2);
    cmd_drv[0] = '0; data_drv[0] = '0;
    expect_resp(0, 2'd1, 32'd11, e0 + 3);
    tick(6);
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL ignore_drain: got %0d left, want 0", sb.size()); end
  endtask

  task automatic test_reset_mid();
    int e0;
    op_cmd[0] = 4'd1; op_d1[0] = 32'd1; op_d2[0] = 32'd2;
    start_ops(e0);
    reset = 1'b1;
    #1;
    checks++;
    if (busy !== 4'b0000) begin errors++; $display("FAIL midreset_busy: got %b, want 0000", busy); end
    tick(2);
    checks++;
    if (out_resp[0] !== 2'd0 || out_data[0] !== '0) begin
      errors++; $display("FAIL midreset_out: got resp %0d data %h, want 0/0", out_resp[0], out_data[0]);
    end
    reset = 1'b0;
    op_cmd[1] = 4'd1; op_d1[1] = 32'd7; op_d2[1] = 32'd8;
    start_ops(e0);
    expect_resp(1, 2'd1, 32'd15, e0 + 3);
    tick(6);
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL midreset_drain: got %0d left, want 0", sb.size()); end
  endtask

  initial begin
    test_reset();
    test_add_basic();
    test_errors();
    test_all_ports();
    test_round_robin();
    test_pipeline();
    test_invalid_shift();
    test_back_to_back();
    test_ignore_pend();
    test_reset_mid();
    tick(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
